// File: rtl/cla_adder_pipe.sv
// cla_adder_pipe: pipelined carry-lookahead adder/subtractor with valid/ready flow control.
// Each stage resolves STG_GRP lookahead groups of GRP bits; the carry between stages is registered.
// Optional build macro CLA_ADDER_PIPE_SAT_EN: saturate o_s to the signed limit on overflow.

module cla_adder_slice #(
    parameter int GRP = 4,
    parameter int NG  = 2
) (
    input  logic [GRP*NG-1:0] i_a,
    input  logic [GRP*NG-1:0] i_b,
    input  logic              i_cin,
    output logic [GRP*NG-1:0] o_s,
    output logic              o_cout,
    output logic              o_cmsb
);
    localparam int W = GRP*NG;

    logic [W-1:0] w_p;
    logic [W-1:0] w_g;
    logic [W:0]   w_cb;

    assign w_p = i_a ^ i_b;
    assign w_g = i_a & i_b;

    // Carry into every bit: two-level lookahead inside a group, group carry-outs chained
    always_comb begin
        logic gc;
        logic c;
        logic t;
        w_cb    = '0;
        w_cb[0] = i_cin;
        gc      = i_cin;
        c       = 1'b0;
        t       = 1'b0;
        for (int gi = 0; gi < NG; gi++) begin
            for (int j = 1; j <= GRP; j++) begin
                c = gc;
                for (int k = 0; k < j; k++) c = c & w_p[gi*GRP+k];
                for (int k = 0; k < j; k++) begin
                    t = w_g[gi*GRP+k];
                    for (int m = k + 1; m < j; m++) t = t & w_p[gi*GRP+m];
                    c = c | t;
                end
                w_cb[gi*GRP+j] = c;
            end
            gc = c;
        end
    end

    assign o_s    = w_p ^ w_cb[W-1:0];
    assign o_cout = w_cb[W];
    assign o_cmsb = w_cb[W-1];
endmodule

module cla_adder_pipe #(
    parameter int WIDTH   = 32,
    parameter int GRP     = 4,
    parameter int STG_GRP = 2
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_c,
    input  logic             i_sub,
    input  logic             i_vld,
    output logic             o_rdy,
    output logic [WIDTH-1:0] o_s,
    output logic             o_c,
    output logic             o_ovf,
    output logic             o_vld,
    input  logic             i_rdy
);
    localparam int SW   = GRP*STG_GRP;
    localparam int NSTG = WIDTH/SW;

    // a/b travel forward for the upper slices, s accumulates finished slices,
    // c is the carry out of the highest slice done so far, cm the carry into that bit
    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] s;
        logic             c;
        logic             cm;
    } stg_t;

    stg_t            r_stg [NSTG];
    stg_t            w_nxt [NSTG];
    logic [NSTG-1:0] r_vld;
    logic            w_stall;
    logic            w_acc;
    logic [WIDTH-1:0] w_beff;
    logic            w_cin;

    assign w_beff  = i_sub ? ~i_b : i_b;
    assign w_cin   = i_sub ? 1'b1 : i_c;
    assign w_stall = r_vld[NSTG-1] & ~i_rdy;
    assign o_rdy   = ~w_stall;
    assign w_acc   = i_vld & ~w_stall;

    for (genvar k = 0; k < NSTG; k++) begin : g_stg
        logic [WIDTH-1:0] w_a;
        logic [WIDTH-1:0] w_b;
        logic [WIDTH-1:0] w_sin;
        logic             w_ci;
        logic [SW-1:0]    w_s;
        logic             w_co;
        logic             w_cm;
        logic [WIDTH-1:0] w_sm;

        if (k == 0) begin : g_first
            assign w_a   = i_a;
            assign w_b   = w_beff;
            assign w_sin = '0;
            assign w_ci  = w_cin;
        end else begin : g_rest
            assign w_a   = r_stg[k-1].a;
            assign w_b   = r_stg[k-1].b;
            assign w_sin = r_stg[k-1].s;
            assign w_ci  = r_stg[k-1].c;
        end

        cla_adder_slice #(.GRP(GRP), .NG(STG_GRP)) u_slice (
            .i_a    (w_a[k*SW +: SW]),
            .i_b    (w_b[k*SW +: SW]),
            .i_cin  (w_ci),
            .o_s    (w_s),
            .o_cout (w_co),
            .o_cmsb (w_cm)
        );

        // Merge this stage's sum slice into the lower slices carried from upstream
        always_comb begin
            w_sm               = w_sin;
            w_sm[k*SW +: SW]   = w_s;
        end

        assign w_nxt[k] = {w_a, w_b, w_sm, w_co, w_cm};
    end

    // Stage registers and valid shift; the whole pipe freezes while the output is stalled
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            for (int k = 0; k < NSTG; k++) r_stg[k] <= '0;
            r_vld <= '0;
        end else if (!w_stall) begin
            for (int k = 0; k < NSTG; k++) r_stg[k] <= w_nxt[k];
            r_vld[0] <= w_acc;
            for (int k = 1; k < NSTG; k++) r_vld[k] <= r_vld[k-1];
        end
    end

    assign o_vld = r_vld[NSTG-1];
    assign o_c   = r_stg[NSTG-1].c;
    assign o_ovf = r_stg[NSTG-1].c ^ r_stg[NSTG-1].cm;

`ifdef CLA_ADDER_PIPE_SAT_EN
    // Clamp toward the sign of A; carry and overflow flags still describe the raw sum
    assign o_s = o_ovf ? (r_stg[NSTG-1].a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                                   : {1'b0, {(WIDTH-1){1'b1}}})
                       : r_stg[NSTG-1].s;
`else
    assign o_s = r_stg[NSTG-1].s;
`endif
endmodule

// File: tb/tb_cla_adder_pipe.sv
// Self-checking bench for cla_adder_pipe (WIDTH=32, GRP=4, STG_GRP=2 -> 4 stages).
module tb_cla_adder_pipe;
    logic        i_clk;
    logic        i_rstn;
    logic [31:0] i_a;
    logic [31:0] i_b;
    logic        i_c;
    logic        i_sub;
    logic        i_vld;
    logic        o_rdy;
    logic [31:0] o_s;
    logic        o_c;
    logic        o_ovf;
    logic        o_vld;
    logic        i_rdy;

    cla_adder_pipe #(.WIDTH(32), .GRP(4), .STG_GRP(2)) dut (
        .i_clk (i_clk), .i_rstn (i_rstn), .i_a (i_a), .i_b (i_b), .i_c (i_c),
        .i_sub (i_sub), .i_vld (i_vld), .o_rdy (o_rdy), .o_s (o_s), .o_c (o_c),
        .o_ovf (o_ovf), .o_vld (o_vld), .i_rdy (i_rdy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        ci;
        logic        sub;
        logic [31:0] s;
        logic        co;
        logic        ov;
    } vec_t;

`ifdef CLA_ADDER_PIPE_SAT_EN
    localparam logic [31:0] S4 = 32'h7FFFFFFF;
    localparam logic [31:0] S5 = 32'h80000000;
    localparam logic [31:0] S7 = 32'h80000000;
`else
    localparam logic [31:0] S4 = 32'h80000000;
    localparam logic [31:0] S5 = 32'h7FFFFFFF;
    localparam logic [31:0] S7 = 32'h00000001;
`endif

    vec_t tbl [9];
    vec_t sb[$];
    vec_t cur;
    vec_t m_e;
    int   checks = 0;
    int   errors = 0;
    int   n_out  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mdl(input logic [31:0] a, input logic [31:0] b,
                                 input logic ci, input logic sub);
        vec_t        v;
        logic [31:0] bb;
        logic [32:0] f;
        bb    = sub ? ~b : b;
        f     = {1'b0, a} + {1'b0, bb} + {32'd0, (sub ? 1'b1 : ci)};
        v.a   = a; v.b = b; v.ci = ci; v.sub = sub;
        v.s   = f[31:0];
        v.co  = f[32];
        v.ov  = (a[31] == bb[31]) && (f[31] != a[31]);
`ifdef CLA_ADDER_PIPE_SAT_EN
        if (v.ov) v.s = a[31] ? 32'h80000000 : 32'h7FFFFFFF;
`endif
        return v;
    endfunction

    // Scoreboard: push on input transfer, pop and compare on output transfer
    always @(negedge i_clk) begin
        if (i_rstn && i_vld && o_rdy) sb.push_back(cur);
        if (i_rstn && o_vld && i_rdy) begin
            n_out++;
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL out_unexp: got output %h, expected none", o_s);
            end else begin
                m_e = sb.pop_front();
                chk("out_s", o_s, m_e.s);
                chk("out_c", {31'd0, o_c}, {31'd0, m_e.co});
                chk("out_ovf", {31'd0, o_ovf}, {31'd0, m_e.ov});
            end
        end
    end

    task automatic send(input vec_t v);
        int   n;
        logic acc;
        n = 0; acc = 1'b0;
        i_a = v.a; i_b = v.b; i_c = v.ci; i_sub = v.sub; i_vld = 1'b1; cur = v;
        while (!acc && n < 100) begin
            @(negedge i_clk);
            acc = o_rdy;
            @(posedge i_clk); #1;
            n++;
        end
        if (!acc) begin
            checks++; errors++;
            $display("FAIL send_timeout: got no acceptance, expected acceptance within 100 cycles");
        end
        i_vld = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(posedge i_clk);
            n++;
        end
        #1;
        chk("drain_empty", sb.size(), 0);
    endtask

    initial begin
        int   nxt;
        int   n0;
        logic acc;
        logic hold;
        i_rstn = 1'b0; i_a = '0; i_b = '0; i_c = 1'b0; i_sub = 1'b0; i_vld = 1'b0; i_rdy = 1'b1;
        cur = '{32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0};

        tbl[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0};
        tbl[1] = '{32'h0000000F, 32'h00000000, 1'b1, 1'b0, 32'h00000010, 1'b0, 1'b0};
        tbl[2] = '{32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
        tbl[3] = '{32'h00000007, 32'h00000005, 1'b0, 1'b1, 32'h00000002, 1'b1, 1'b0};
        tbl[4] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, S4,           1'b0, 1'b1};
        tbl[5] = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, S5,           1'b1, 1'b1};
        tbl[6] = '{32'h00000010, 32'h00000010, 1'b1, 1'b1, 32'h00000000, 1'b1, 1'b0};
        tbl[7] = '{32'h80000000, 32'h80000000, 1'b1, 1'b0, S7,           1'b1, 1'b1};
        tbl[8] = '{32'h12345678, 32'h0FEDCBA9, 1'b0, 1'b0, 32'h22222221, 1'b0, 1'b0};

        // Reset state
        #12;
        chk("rst_vld", {31'd0, o_vld}, 32'd0);
        chk("rst_rdy", {31'd0, o_rdy}, 32'd1);
        chk("rst_s", o_s, 32'd0);
        chk("rst_c", {31'd0, o_c}, 32'd0);
        chk("rst_ovf", {31'd0, o_ovf}, 32'd0);
        @(negedge i_clk); i_rstn = 1'b1;
        @(posedge i_clk); #1;

        // First result appears in the 4th cycle after acceptance
        send(tbl[0]);
        for (int i = 0; i < 4; i++) begin
            @(negedge i_clk);
            chk("lat_vld", {31'd0, o_vld}, (i == 3) ? 32'd1 : 32'd0);
        end
        @(posedge i_clk); #1;

        // Directed vectors back to back
        for (int i = 1; i < 9; i++) send(tbl[i]);
        drain();

        // Stream of 8 adds with downstream stall in cycles 5..7
        n0 = n_out; nxt = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            i_rdy = !(cyc >= 5 && cyc <= 7);
            if (nxt < 8) begin
                i_a = nxt; i_b = 32'h10; i_c = 1'b0; i_sub = 1'b0; i_vld = 1'b1;
                cur = '{nxt, 32'h10, 1'b0, 1'b0, 32'h10 + nxt, 1'b0, 1'b0};
            end else begin
                i_vld = 1'b0;
            end
            @(negedge i_clk);
            chk("strm_rdy", {31'd0, o_rdy}, (cyc >= 5 && cyc <= 7) ? 32'd0 : 32'd1);
            if (cyc >= 5 && cyc <= 7) begin
                chk("strm_hold_s", o_s, 32'h11);
                chk("strm_hold_vld", {31'd0, o_vld}, 32'd1);
            end
            acc = i_vld && o_rdy;
            @(posedge i_clk); #1;
            if (acc) nxt++;
        end
        i_vld = 1'b0; i_rdy = 1'b1;
        chk("strm_cnt", n_out - n0, 8);
        drain();

        // Random traffic with random back-pressure
        hold = 1'b0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            i_rdy = ($urandom_range(0, 3) != 0);
            if (!hold) begin
                cur   = mdl($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                i_a   = cur.a; i_b = cur.b; i_c = cur.ci; i_sub = cur.sub;
                i_vld = ($urandom_range(0, 4) != 0);
            end
            @(negedge i_clk);
            acc = i_vld && o_rdy;
            @(posedge i_clk); #1;
            hold = i_vld && !acc;
        end
        i_vld = 1'b0; i_rdy = 1'b1;
        drain();

        // Asynchronous reset with three operations in flight
        send(mdl(32'hC0000000, 32'h80000000, 1'b0, 1'b0));
        send(mdl(32'h00000001, 32'h00000002, 1'b0, 1'b0));
        send(mdl(32'h00000003, 32'h00000004, 1'b0, 1'b0));
        @(posedge i_clk); #1;
        chk("pre_rst_vld", {31'd0, o_vld}, 32'd1);
        #2 i_rstn = 1'b0;
        #1;
        sb.delete();
        chk("arst_vld", {31'd0, o_vld}, 32'd0);
        chk("arst_s", o_s, 32'd0);
        chk("arst_c", {31'd0, o_c}, 32'd0);
        chk("arst_ovf", {31'd0, o_ovf}, 32'd0);
        chk("arst_rdy", {31'd0, o_rdy}, 32'd1);
        #13 i_rstn = 1'b1;
        n0 = n_out;
        for (int i = 0; i < 8; i++) begin
            @(negedge i_clk);
            chk("post_rst_vld", {31'd0, o_vld}, 32'd0);
            chk("post_rst_rdy", {31'd0, o_rdy}, 32'd1);
        end
        @(posedge i_clk); #1;
        send(mdl(32'h0000ABCD, 32'h00001111, 1'b1, 1'b0));
        drain();
        chk("post_rst_cnt", n_out - n0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got simulation still running, expected completion");
        $fatal(1, "timeout");
    end
endmodule
